// File: rtl/sha3_padder.sv
// SHA-3 pad10*1 byte padder: packs a byte stream into rate-sized blocks and
// appends the 0x06 .. 0x80 domain/pad pattern, splitting into an extra block when needed.
//
// state | meaning
// FILL  | accepting message bytes into the block register
// PAD   | one cycle writing the pad pattern from byte cnt upward
// OUT   | block presented, waiting for block_ready
module sha3_padder #(
  parameter int D = 512,
  parameter int R = 1600 - 2*D
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [7:0]   in_data,
  input  logic         in_keep,
  input  logic         in_last,
  output logic [R-1:0] block,
  output logic         block_valid,
  input  logic         block_ready,
  output logic         block_last
);
  localparam int NB = R / 8;
  localparam int CW = $clog2(NB);
  localparam logic [CW-1:0] LAST_IDX = CW'(NB - 1);

  localparam logic [1:0] FILL = 2'd0;
  localparam logic [1:0] PAD  = 2'd1;
  localparam logic [1:0] OUT  = 2'd2;

  logic [1:0]    state;
  logic [CW-1:0] cnt;
  logic          pp;
  logic          armed;
  logic          take;
  logic          drain;

  // armed keeps in_ready low until the first edge after reset release
  assign in_ready    = armed && (state == FILL);
  assign block_valid = (state == OUT);
  assign take        = in_valid && in_ready;
  assign drain       = block_valid && block_ready;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) armed <= 1'b0;
    else        armed <= 1'b1;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state      <= FILL;
      cnt        <= '0;
      pp         <= 1'b0;
      block      <= '0;
      block_last <= 1'b0;
    end else begin
      case (state)
        FILL: begin
          if (take) begin
            if (in_keep) begin
              for (int k = 0; k < NB; k++) begin
                if (CW'(k) == cnt) block[R-1-8*k -: 8] <= in_data;
              end
              if (cnt == LAST_IDX) begin
                // full block with last set: the pad needs a whole extra block
                state      <= OUT;
                block_last <= 1'b0;
                cnt        <= '0;
                pp         <= in_last;
              end else begin
                cnt <= cnt + 1'b1;
                if (in_last) state <= PAD;
              end
            end else if (in_last) begin
              state <= PAD;
            end
          end
        end
        PAD: begin
          // bytes below cnt keep message data; 0x06 and 0x80 merge when cnt is the last byte
          for (int k = 0; k < NB; k++) begin
            if (CW'(k) == cnt)
              block[R-1-8*k -: 8] <= (k == NB - 1) ? 8'h86 : 8'h06;
            else if (CW'(k) > cnt)
              block[R-1-8*k -: 8] <= (k == NB - 1) ? 8'h80 : 8'h00;
          end
          state      <= OUT;
          block_last <= 1'b1;
        end
        OUT: begin
          if (drain) begin
            cnt <= '0;
            if (pp) begin
              pp    <= 1'b0;
              state <= PAD;
            end else begin
              state <= FILL;
              block <= '0;
            end
          end
        end
        default: state <= FILL;
      endcase
    end
  end

endmodule

// File: tb/tb_sha3_padder.sv
// Bench for sha3_padder (D=512, 72-byte rate): table of messages checked
// against a pad10*1 reference, plus stall, latency and mid-message reset sequences.
module tb_sha3_padder;
  localparam int D  = 512;
  localparam int R  = 1600 - 2*D;
  localparam int NB = R / 8;

  logic         clk = 1'b0;
  logic         reset = 1'b0;
  logic         in_valid = 1'b0;
  logic [7:0]   in_data = 8'h00;
  logic         in_keep = 1'b0;
  logic         in_last = 1'b0;
  logic         block_ready = 1'b0;
  logic         in_ready;
  logic [R-1:0] block;
  logic         block_valid;
  logic         block_last;

  int checks = 0;
  int errors = 0;
  int beats  = 0;
  logic [R-1:0] got_blk[$];
  bit           got_last[$];

  typedef struct {
    int len;
    int base;
    bit tail;
    int nblk;
  } vec_t;
  vec_t vecs[10];

  sha3_padder #(.D(D), .R(R)) dut (
    .clk         (clk),
    .reset       (reset),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .in_data     (in_data),
    .in_keep     (in_keep),
    .in_last     (in_last),
    .block       (block),
    .block_valid (block_valid),
    .block_ready (block_ready),
    .block_last  (block_last)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (block_valid && block_ready) begin
      got_blk.push_back(block);
      got_last.push_back(block_last);
    end
    if (in_valid && in_ready) beats++;
  end

  task automatic chk_i(string name, int act, int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic chk_b(string name, logic [R-1:0] act, logic [R-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // reference: msg || 0x06 || 0.. || 0x80 over ceil((len+1)/NB) blocks
  function automatic logic [R-1:0] exp_block(int len, int base, int j);
    logic [R-1:0] v;
    logic [7:0]   b;
    int           p;
    int           plen;
    v    = '0;
    plen = (len / NB + 1) * NB;
    for (int k = 0; k < NB; k++) begin
      p = j * NB + k;
      b = (p < len) ? 8'(base + p) : 8'h00;
      if (p == len)      b = b | 8'h06;
      if (p == plen - 1) b = b | 8'h80;
      v[R-1-8*k -: 8] = b;
    end
    return v;
  endfunction

  task automatic send_beat(logic [7:0] d, logic k, logic l);
    int t;
    t = 0;
    @(negedge clk);
    in_valid = 1'b1;
    in_data  = d;
    in_keep  = k;
    in_last  = l;
    while (!in_ready && t < 500) begin
      @(negedge clk);
      t++;
    end
    if (!in_ready) begin
      checks++;
      errors++;
      $display("FAIL beat_timeout: in_ready still %0d after %0d cycles, required 1", in_ready, t);
    end
    @(posedge clk);
    #1 in_valid = 1'b0;
  endtask

  task automatic send_msg(int len, int base, bit tail);
    for (int i = 0; i < len; i++)
      send_beat(8'(base + i), 1'b1, (!tail && i == len - 1));
    if (tail) send_beat(8'h00, 1'b0, 1'b1);
  endtask

  task automatic wait_blocks(int n);
    int t;
    t = 0;
    while (got_blk.size() < n && t < 2000) begin
      @(negedge clk);
      t++;
    end
    repeat (4) @(negedge clk);
  endtask

  logic [R-1:0] exp_empty;
  logic [R-1:0] exp_abc;
  logic [R-1:0] hold;
  int           beats0;

  initial begin
    vecs[0] = '{len: 0,   base: 0,    tail: 1'b1, nblk: 1};
    vecs[1] = '{len: 3,   base: 'h61, tail: 1'b0, nblk: 1};
    vecs[2] = '{len: 71,  base: 0,    tail: 1'b0, nblk: 1};
    vecs[3] = '{len: 72,  base: 0,    tail: 1'b0, nblk: 2};
    vecs[4] = '{len: 70,  base: 'h10, tail: 1'b0, nblk: 1};
    vecs[5] = '{len: 5,   base: 'hA0, tail: 1'b1, nblk: 1};
    vecs[6] = '{len: 72,  base: 'h30, tail: 1'b1, nblk: 2};
    vecs[7] = '{len: 100, base: 7,    tail: 1'b0, nblk: 2};
    vecs[8] = '{len: 143, base: 0,    tail: 1'b0, nblk: 2};
    vecs[9] = '{len: 144, base: 'h80, tail: 1'b0, nblk: 3};

    exp_empty = '0;
    exp_empty[R-1 -: 8] = 8'h06;
    exp_empty[7:0]      = 8'h80;
    exp_abc = '0;
    exp_abc[R-1 -: 32] = 32'h61626306;
    exp_abc[7:0]       = 8'h80;

    // reset state
    repeat (2) @(negedge clk);
    chk_i("rst_in_ready", int'(in_ready), 0);
    chk_i("rst_block_valid", int'(block_valid), 0);
    chk_i("rst_block_last", int'(block_last), 0);
    chk_b("rst_block", block, '0);
    reset = 1'b1;
    #1 chk_i("rel_in_ready_before_edge", int'(in_ready), 0);
    @(negedge clk);
    chk_i("rel_in_ready_after_edge", int'(in_ready), 1);

    block_ready = 1'b1;
    for (int i = 0; i < 10; i++) begin
      got_blk.delete();
      got_last.delete();
      send_msg(vecs[i].len, vecs[i].base, vecs[i].tail);
      wait_blocks(vecs[i].nblk);
      chk_i($sformatf("v%0d_nblocks", i), got_blk.size(), vecs[i].nblk);
      for (int j = 0; j < vecs[i].nblk && j < got_blk.size(); j++) begin
        chk_b($sformatf("v%0d_blk%0d", i, j), got_blk[j], exp_block(vecs[i].len, vecs[i].base, j));
        chk_i($sformatf("v%0d_last%0d", i, j), int'(got_last[j]), (j == vecs[i].nblk - 1) ? 1 : 0);
      end
    end

    // literal abc block
    got_blk.delete();
    got_last.delete();
    send_msg(3, 'h61, 1'b0);
    wait_blocks(1);
    chk_i("abc_nblocks", got_blk.size(), 1);
    if (got_blk.size() > 0) chk_b("abc_block", got_blk[0], exp_abc);

    // empty message latency and 10-cycle back-pressure
    block_ready = 1'b0;
    got_blk.delete();
    got_last.delete();
    beats0 = beats;
    send_beat(8'h00, 1'b0, 1'b1);
    @(negedge clk);
    chk_i("lat_pad_cycle_valid", int'(block_valid), 0);
    @(negedge clk);
    chk_i("lat_out_cycle_valid", int'(block_valid), 1);
    chk_b("stall_empty_block", block, exp_empty);
    hold = block;
    in_valid = 1'b1;
    in_keep  = 1'b1;
    in_data  = 8'h55;
    in_last  = 1'b0;
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      chk_b("stall_block_stable", block, hold);
      chk_i("stall_last_stable", int'(block_last), 1);
      chk_i("stall_in_ready_low", int'(in_ready), 0);
      chk_i("stall_valid_high", int'(block_valid), 1);
    end
    in_valid = 1'b0;
    chk_i("stall_beats_accepted", beats - beats0, 1);
    block_ready = 1'b1;
    @(negedge clk);
    chk_i("stall_released_valid", int'(block_valid), 0);
    chk_i("stall_released_count", got_blk.size(), 1);

    // reset in the middle of a message
    for (int i = 0; i < 30; i++) send_beat(8'(i + 1), 1'b1, 1'b0);
    @(negedge clk);
    reset = 1'b0;
    #1;
    chk_b("midrst_block", block, '0);
    chk_i("midrst_in_ready", int'(in_ready), 0);
    chk_i("midrst_valid", int'(block_valid), 0);
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    got_blk.delete();
    got_last.delete();
    send_msg(3, 'h61, 1'b0);
    wait_blocks(1);
    chk_i("midrst_nblocks", got_blk.size(), 1);
    if (got_blk.size() > 0) begin
      chk_b("midrst_abc_block", got_blk[0], exp_abc);
      chk_i("midrst_abc_last", int'(got_last[0]), 1);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL global_timeout: simulation time exceeded, checks %0d errors %0d", checks, errors);
    $fatal(1, "timeout");
  end

endmodule

// File: doc/sha3_padder.md
SHA3_PADDER -- requirements
Module: sha3_padder

Interface
REQ-001 Parameter D, default 512, digest width in bits; legal values 224, 256, 384, 512.
REQ-002 Parameter R, default 1600-2*D, rate in bits; R/8 = NB bytes per block (72 for D=512).
REQ-003 clk  input  1  sole clock; all state updates on rising edge.
REQ-004 reset  input  1  asynchronous, active-low reset.
REQ-005 in_valid  input  1  byte beat offered.
REQ-006 in_ready  output  1  beat accepted when in_valid && in_ready at clk edge.
REQ-007 in_data  input  8  message byte.
REQ-008 in_keep  input  1  in_data carries a message byte; 0 legal only with in_last=1 (empty tail).
REQ-009 in_last  input  1  final beat of message.
REQ-010 block  output  R  padded rate block; first message byte at block[R-1:R-8], byte k at block[R-1-8k -: 8].
REQ-011 block_valid  output  1  block presented.
REQ-012 block_ready  input  1  block consumed when block_valid && block_ready at clk edge.
REQ-013 block_last  output  1  block is final block of the message (qualified by block_valid).

Function
REQ-014 States: FILL, PAD, OUT; byte counter cnt 0..NB-1; pending-pad flag pp.
REQ-015 FILL: in_ready=1; accepted beat with in_keep=1 writes in_data to byte cnt, cnt increments.
REQ-016 FILL, accepted keep=1 beat with cnt=NB-1 -> OUT with block_last=0, cnt=0; if in_last also set, pp=1.
REQ-017 FILL, accepted beat with in_last=1 and block not filled by it -> PAD.
REQ-018 PAD, one cycle, in_ready=0: byte cnt = 0x06, bytes cnt+1..NB-2 = 0x00, byte NB-1 = 0x80; if cnt=NB-1 that byte = 0x86; -> OUT with block_last=1.
REQ-019 OUT: in_ready=0, block and block_last held stable until handshake.
REQ-020 OUT handshake: if pp=1, clear pp, cnt=0 -> PAD (produces full pad block 0x06,00..00,0x80); else -> FILL with cnt=0 and block bytes cleared.
REQ-021 block_valid=1 exactly in OUT; earliest block_valid is the cycle after the accepting edge (FILL->OUT) or after PAD (in_last case, latency 2).
REQ-022 block_ready may be held high continuously; block_ready with block_valid=0 is ignored.
REQ-023 in_valid while in_ready=0 has no effect; the beat is not consumed.
REQ-024 Empty message (single beat keep=0, last=1, cnt=0) -> one block: 0x06, NB-2 zeros, 0x80, last=1.
REQ-025 Throughput: a full block needs NB accepted beats plus one OUT cycle minimum; back-to-back messages allowed, new message starts in FILL after final-block handshake.

Reset
REQ-026 reset low asynchronously forces FILL, cnt=0, pp=0, block=0, block_valid=0, block_last=0, in_ready=0.
REQ-027 in_ready rises to 1 on the first clk edge after reset deasserts; any partially filled or unconsumed block is discarded.

Verification (D=512, NB=72)
REQ-028 Empty message beat -> single block 0x06 || 70x 0x00 || 0x80, block_last=1, 2 cycles after beat.
REQ-029 Bytes "abc" (0x61,0x62,0x63 last on 0x63) -> block 0x616263 || 0x06 || 67x 0x00 || 0x80, last=1.
REQ-030 71 bytes 0x00..0x46, last on 71st -> one block, byte 70=0x46, byte 71=0x86, last=1.
REQ-031 72 bytes, last on 72nd -> block 1 = data, last=0; block 2 = 0x06 || 70x 0x00 || 0x80, last=1.
REQ-032 block_ready low 10 cycles while block_valid=1 -> block, block_last stable, in_ready=0 throughout, no beats accepted.
REQ-033 reset asserted after 30 bytes, then "abc" -> output identical to REQ-029, no residue from the 30 bytes.
